io_cycle_sequencer: RTL

//  Sequences every CPU I/O bus cycle onto the 8-bit port-decode fabric. Latches the request,

---
 rtl/io_cycle_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/io_cycle_sequencer.sv
// Sequences one CPU I/O bus cycle at a time onto the port-decode fabric:
// setup, timed read/write strobe (stretched for slow ports or port_wait), hold, done.
module io_cycle_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned SLOW_CYC    = 6,
    parameter int unsigned HOLD_CYC    = 1,
    parameter logic [7:0]  SLOW_BASE   = 8'h34,
    parameter logic [7:0]  SLOW_MASK   = 8'hFE,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       io_req,
    input  logic       io_wr,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    input  logic [7:0] port_rdata,
    input  logic       port_wait,
    output logic [7:0] port_addr,
    output logic [7:0] port_wdata,
    output logic       ioread,
    output logic       iowrite,
    output logic       io_busy,
    output logic       io_done,
    output logic [7:0] io_rdata,
    output logic       io_timeout
);

    localparam logic [3:0] SETUP_N   = (SETUP_CYC   == 0) ? 4'd1 : 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_N  = (STROBE_CYC  == 0) ? 4'd1 : 4'(STROBE_CYC);
    localparam logic [3:0] SLOW_N    = (SLOW_CYC    == 0) ? 4'd1 : 4'(SLOW_CYC);
    localparam logic [3:0] HOLD_N    = (HOLD_CYC    == 0) ? 4'd1 : 4'(HOLD_CYC);
    localparam logic [7:0] TIMEOUT_N = (TIMEOUT_CYC == 0) ? 8'd1 : 8'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] scnt_q, scnt_d;
    logic       wr_q, wr_d;
    logic       slow_q, slow_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ioread_q, ioread_d;
    logic       iowrite_q, iowrite_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       timeout_q, timeout_d;
    logic [7:0] width_c;

    assign width_c = {4'd0, (slow_q ? SLOW_N : STROBE_N)};

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        wr_d      = wr_q;
        slow_d    = slow_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ioread_d  = 1'b0;
        iowrite_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (io_req) begin
                    wr_d      = io_wr;
                    addr_d    = io_addr;
                    wdata_d   = io_wdata;
                    slow_d    = ((io_addr & SLOW_MASK) == (SLOW_BASE & SLOW_MASK));
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q >= SETUP_N) begin
                    state_d   = S_STROBE;
                    scnt_d    = 8'd1;
                    ioread_d  = ~wr_q;
                    iowrite_d = wr_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STROBE: begin
                if ((scnt_q >= width_c) && !port_wait) begin
                    state_d = S_HOLD;
                    cnt_d   = 4'd1;
                    if (!wr_q) rdata_d = port_rdata;
                end else if (port_wait && (scnt_q >= TIMEOUT_N)) begin
                    // Hung port: abandon the transfer, reads return all-ones.
                    state_d   = S_HOLD;
                    cnt_d     = 4'd1;
                    timeout_d = 1'b1;
                    if (!wr_q) rdata_d = 8'hFF;
                end else begin
                    ioread_d  = ~wr_q;
                    iowrite_d = wr_q;
                    if (scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q >= HOLD_N) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            scnt_q    <= 8'd0;
            wr_q      <= 1'b0;
            slow_q    <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            ioread_q  <= 1'b0;
            iowrite_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'hFF;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scnt_q    <= scnt_d;
            wr_q      <= wr_d;
            slow_q    <= slow_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ioread_q  <= ioread_d;
            iowrite_q <= iowrite_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign port_addr  = addr_q;
    assign port_wdata = wdata_q;
    assign ioread     = ioread_q;
    assign iowrite    = iowrite_q;
    assign io_busy    = busy_q;
    assign io_done    = done_q;
    assign io_rdata   = rdata_q;
    assign io_timeout = timeout_q;

endmodule
